// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a small output FIFO and a valid/ready interface.
// Reports framing errors (low stop bit) and overruns (byte arriving while full).
module uart_rx_fifo #(
  parameter int BAUD_DIV = 416,
  parameter int DEPTH    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_rx_s, r_rx_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_mem [DEPTH];
  logic [AW:0]      r_wr, r_rd;
  logic             r_valid, r_ferr, r_ovr;
  logic [7:0]       r_data;

  logic             w_fall, w_tick;
  logic             w_load_half, w_load_full, w_shift, w_push, w_ferr;
  logic             w_full, w_pop, w_wr_en, w_ovr;
  logic [AW:0]      w_wr_nxt, w_rd_nxt;
  logic [7:0]       w_head_nxt;

  // i_rx is asynchronous; r_rx_prev feeds the falling-edge detector
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s;
  assign w_tick = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_shift     = 1'b0;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_fall) begin
                 w_state_nxt = S_START;
                 w_load_half = 1'b1;
               end
      S_START: if (w_tick) begin
                 if (r_rx_s) w_state_nxt = S_IDLE;
                 else begin
                   w_state_nxt = S_DATA;
                   w_load_full = 1'b1;
                 end
               end
      S_DATA:  if (w_tick) begin
                 w_shift     = 1'b1;
                 w_load_full = 1'b1;
                 if (r_bit == 3'd7) w_state_nxt = S_STOP;
               end
      S_STOP:  if (w_tick) begin
                 if (r_rx_s) begin
                   w_push      = 1'b1;
                   w_state_nxt = S_IDLE;
                 end else begin
                   w_ferr      = 1'b1;
                   w_state_nxt = S_BREAK;
                 end
               end
      S_BREAK: if (r_rx_s) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Half-bit load on the start edge puts every later sample mid-bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_bit <= 3'd0;
    end else begin
      if (w_load_half)      r_cnt <= HALF_M1;
      else if (w_load_full) r_cnt <= FULL_M1;
      else if (!w_tick)     r_cnt <= r_cnt - CNT_W'(1);
      if (w_shift)          r_bit <= r_bit + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_shift) r_shift <= {r_rx_s, r_shift[7:1]};
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= r_shift;
  end

  assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop    = r_valid & i_ready;
  assign w_wr_en  = w_push & (~w_full | w_pop);
  assign w_ovr    = w_push & w_full & ~w_pop;
  assign w_wr_nxt = r_wr + (AW+1)'(w_wr_en);
  assign w_rd_nxt = r_rd + (AW+1)'(w_pop);

  // A byte written this cycle that becomes the head bypasses the memory
  assign w_head_nxt = (w_wr_en && (w_rd_nxt[AW-1:0] == r_wr[AW-1:0]))
                      ? r_shift : r_mem[w_rd_nxt[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_valid <= (w_wr_nxt != w_rd_nxt);
      if (w_wr_nxt != w_rd_nxt) r_data <= w_head_nxt;
      r_ferr  <= w_ferr;
      r_ovr   <= w_ovr;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_frame_err = r_ferr;
  assign o_overrun   = r_ovr;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at BAUD_DIV=8, DEPTH=4 with ideal-rate frames.
module tb_uart_rx_fifo;

  localparam int BAUD = 8;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_rx, i_ready;
  logic       o_valid, o_frame_err, o_overrun, o_busy;
  logic [7:0] o_data;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int base_f, base_o;
  bit cap_en = 1'b0;
  logic [7:0] capq [$];

  uart_rx_fifo #(.BAUD_DIV(BAUD), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx(i_rx),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_frame_err === 1'b1) ferr_cnt++;
    if (o_overrun === 1'b1)   ovr_cnt++;
    if (cap_en && o_valid === 1'b1 && i_ready === 1'b1) capq.push_back(o_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sync_pos();
    @(posedge i_clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    i_rx = v;
    wait_cyc(BAUD);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic pop_one();
    i_ready = 1'b1;
    sync_pos();
    i_ready = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'h00);
    chk("rst_ferr", {31'd0, o_frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, o_overrun}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    sync_pos();
    i_rst_n = 1'b1;
    wait_cyc(4);

    // Single byte: latency 79 cycles from the start edge
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (78) @(posedge i_clk);
        @(negedge i_clk);
        chk("lat_valid_78", {31'd0, o_valid}, 32'd0);
        @(negedge i_clk);
        chk("lat_valid_79", {31'd0, o_valid}, 32'd1);
      end
    join
    @(negedge i_clk);
    chk("single_data", {24'd0, o_data}, 32'h55);
    chk("single_busy", {31'd0, o_busy}, 32'd0);
    sync_pos();
    pop_one();
    @(negedge i_clk);
    chk("single_pop_valid", {31'd0, o_valid}, 32'd0);

    // Glitch rejection
    base_f = ferr_cnt; base_o = ovr_cnt;
    sync_pos();
    i_rx = 1'b0;
    wait_cyc(3);
    i_rx = 1'b1;
    @(negedge i_clk);
    chk("glitch_busy_start", {31'd0, o_busy}, 32'd1);
    wait_cyc(12);
    @(negedge i_clk);
    chk("glitch_busy_idle", {31'd0, o_busy}, 32'd0);
    chk("glitch_valid", {31'd0, o_valid}, 32'd0);
    chk("glitch_ferr", ferr_cnt - base_f, 32'd0);
    chk("glitch_ovr", ovr_cnt - base_o, 32'd0);

    // Framing error followed by a long break
    sync_pos();
    base_f = ferr_cnt;
    send_frame(8'hA3, 1'b0);
    wait_cyc(200);
    i_rx = 1'b1;
    wait_cyc(10);
    @(negedge i_clk);
    chk("break_ferr_count", ferr_cnt - base_f, 32'd1);
    chk("break_valid", {31'd0, o_valid}, 32'd0);
    chk("break_busy", {31'd0, o_busy}, 32'd0);
    sync_pos();
    send_frame(8'h0F, 1'b1);
    wait_cyc(3);
    @(negedge i_clk);
    chk("after_break_valid", {31'd0, o_valid}, 32'd1);
    chk("after_break_data", {24'd0, o_data}, 32'h0F);
    sync_pos();
    pop_one();

    // Overrun: five back-to-back frames into a 4-deep FIFO
    base_o = ovr_cnt; base_f = ferr_cnt;
    sync_pos();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    wait_cyc(5);
    @(negedge i_clk);
    chk("ovr_count", ovr_cnt - base_o, 32'd1);
    chk("ovr_ferr", ferr_cnt - base_f, 32'd0);
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", {31'd0, o_valid}, 32'd1);
      chk("drain_data", {24'd0, o_data}, 32'(k));
      @(negedge i_clk);
    end
    chk("drain_empty", {31'd0, o_valid}, 32'd0);
    i_ready = 1'b0;

    // Streaming with wrap-around
    base_o = ovr_cnt; base_f = ferr_cnt;
    capq.delete();
    sync_pos();
    cap_en  = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) send_frame(8'h30 + 8'(k), 1'b1);
    wait_cyc(5);
    cap_en  = 1'b0;
    i_ready = 1'b0;
    chk("wrap_count", capq.size(), 32'd10);
    for (int k = 0; k < 10; k++)
      chk("wrap_data", (k < capq.size()) ? {24'd0, capq[k]} : 32'hFFFF, 32'h30 + k);
    chk("wrap_ferr", ferr_cnt - base_f, 32'd0);
    chk("wrap_ovr", ovr_cnt - base_o, 32'd0);

    // Reset mid-frame with two bytes buffered
    sync_pos();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cyc(3);
    @(negedge i_clk);
    chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
    sync_pos();
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (44) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, o_valid}, 32'd0);
        chk("arst_data", {24'd0, o_data}, 32'h00);
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        chk("arst_ferr", {31'd0, o_frame_err}, 32'd0);
        chk("arst_ovr", {31'd0, o_overrun}, 32'd0);
      end
    join
    wait_cyc(2);
    i_rst_n = 1'b1;
    wait_cyc(3);
    @(negedge i_clk);
    chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, o_busy}, 32'd0);
    capq.delete();
    sync_pos();
    cap_en  = 1'b1;
    i_ready = 1'b1;
    send_frame(8'h7E, 1'b1);
    wait_cyc(5);
    cap_en  = 1'b0;
    i_ready = 1'b0;
    chk("post_rst_count", capq.size(), 32'd1);
    chk("post_rst_data", (capq.size() > 0) ? {24'd0, capq[0]} : 32'hFFFF, 32'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
